// File: rtl/word_packer_if.sv
// Handshake bundle for word_packer: narrow-word input stream and packed-block output.
interface word_packer_if #(
   parameter int N = 128,
   parameter int W = 8
);
   localparam int K  = N / W;
   localparam int CW = $clog2(K);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;
   logic          we;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, we, count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, we, count
   );
endinterface

// File: rtl/word_packer.sv
// Packs K = N/W narrow words into one N-bit registered block with a one-cycle we pulse.
// Define WORD_PACKER_LSB_FIRST_EN to place word 0 in the LSBs instead of the MSBs.
module word_packer #(
   parameter int N = 128,
   parameter int W = 8
) (
   input logic          clk,
   input logic          rst,
   input logic          clear,
   word_packer_if.slave bus
);
   localparam int K  = N / W;
   localparam int CW = $clog2(K);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   logic [N-1:0]  asm_q, asm_d, asm_ins;
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0]  out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          we_q, we_d;
   logic          in_ready;
   logic          accept;

   // Only the completing word stalls, and only behind an unconsumed block.
   assign in_ready = !clear && !(count_q == LAST && out_valid_q && !bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      asm_ins = asm_q;
      for (int unsigned i = 0; i < K; i++) begin
         if (count_q == CW'(i)) begin
`ifdef WORD_PACKER_LSB_FIRST_EN
            asm_ins[i*W +: W] = bus.in_data;
`else
            asm_ins[(K-1-i)*W +: W] = bus.in_data;
`endif
         end
      end
   end

   always_comb begin
      asm_d       = asm_q;
      count_d     = count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      we_d        = 1'b0;

      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

      if (clear) begin
         count_d = '0;
      end else if (accept) begin
         if (count_q == LAST) begin
            out_data_d  = asm_ins;
            out_valid_d = 1'b1;
            we_d        = 1'b1;
            count_d     = '0;
         end else begin
            asm_d   = asm_ins;
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         asm_q       <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         we_q        <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         we_q        <= we_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.we        = we_q;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_word_packer.sv
// Directed self-checking bench for word_packer (N=128 main instance, N=24 ordering instance).
module tb_word_packer;
   logic clk;
   logic rst;
   logic clear;
   logic clear24;
   int   errors;
   int   checks;

   word_packer_if #(.N(128), .W(8)) bus ();
   word_packer_if #(.N(24),  .W(8)) bus24 ();

   word_packer #(.N(128), .W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   word_packer #(.N(24), .W(8)) dut24 (
      .clk   (clk),
      .rst   (rst),
      .clear (clear24),
      .bus   (bus24)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one word per cycle; ok clears if any word met in_ready low.
   task automatic stream(input logic [7:0] first, input int n, input logic inc, output logic ok);
      logic [7:0] b;
      b  = first;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = b;
         #1;
         if (!bus.in_ready) ok = 1'b0;
         tick();
         if (inc) b = b + 8'd1;
      end
      bus.in_valid = 1'b0;
   endtask

   logic ok;
   logic [23:0] exp24;

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      clear = 1'b0;
      clear24 = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      bus24.in_valid = 1'b0;
      bus24.in_data = '0;
      bus24.out_ready = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         bus.in_valid  = 1'($urandom);
         bus.in_data   = 8'($urandom);
         bus.out_ready = 1'($urandom);
         clear         = 1'($urandom);
         tick();
      end
      clear = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_we",        128'(bus.we),        128'd0);
      check("rst_count",     128'(bus.count),     128'd0);
      check("rst_out_data",  bus.out_data,        128'd0);
      check("rst_in_ready",  128'(bus.in_ready),  128'd1);
      rst = 1'b1;
      tick();

      // Back-to-back block
      bus.out_ready = 1'b1;
      stream(8'h00, 15, 1'b1, ok);
      check("b2b_count15", 128'(bus.count), 128'd15);
      check("b2b_we_early", 128'(bus.we), 128'd0);
      stream(8'h0F, 1, 1'b0, ok);
      check("b2b_data", bus.out_data, 128'h000102030405060708090A0B0C0D0E0F);
      check("b2b_valid", 128'(bus.out_valid), 128'd1);
      check("b2b_we", 128'(bus.we), 128'd1);
      check("b2b_count0", 128'(bus.count), 128'd0);
      tick();
      check("b2b_we_once", 128'(bus.we), 128'd0);
      check("b2b_drained", 128'(bus.out_valid), 128'd0);
      check("b2b_data_kept", bus.out_data, 128'h000102030405060708090A0B0C0D0E0F);

      // Backpressure handoff
      bus.out_ready = 1'b0;
      stream(8'h11, 16, 1'b0, ok);
      check("bp_a_no_stall", 128'(ok), 128'd1);
      check("bp_a_data", bus.out_data, {16{8'h11}});
      stream(8'h22, 15, 1'b0, ok);
      check("bp_15_accepted", 128'(ok), 128'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h22;
      #1;
      check("bp_stall_ready", 128'(bus.in_ready), 128'd0);
      check("bp_stall_count", 128'(bus.count), 128'd15);
      tick();
      check("bp_hold_count", 128'(bus.count), 128'd15);
      check("bp_hold_data", bus.out_data, {16{8'h11}});
      check("bp_hold_we", 128'(bus.we), 128'd0);
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 128'(bus.in_ready), 128'd1);
      tick();
      bus.in_valid = 1'b0;
      check("bp_b_data", bus.out_data, {16{8'h22}});
      check("bp_b_valid", 128'(bus.out_valid), 128'd1);
      check("bp_b_we", 128'(bus.we), 128'd1);
      tick();
      check("bp_drain_valid", 128'(bus.out_valid), 128'd0);

      // Clear
      stream(8'h55, 5, 1'b0, ok);
      check("clr_count5", 128'(bus.count), 128'd5);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      clear = 1'b1;
      #1;
      check("clr_in_ready", 128'(bus.in_ready), 128'd0);
      tick();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      check("clr_count0", 128'(bus.count), 128'd0);
      check("clr_no_we", 128'(bus.we), 128'd0);
      stream(8'hA0, 16, 1'b1, ok);
      check("clr_block", bus.out_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      check("clr_block_we", 128'(bus.we), 128'd1);

      // Async reset mid-block with a held block
      bus.out_ready = 1'b0;
      stream(8'h90, 7, 1'b1, ok);
      check("ar_count7", 128'(bus.count), 128'd7);
      check("ar_held", 128'(bus.out_valid), 128'd1);
      #1;
      rst = 1'b0;
      #1;
      check("ar_valid0", 128'(bus.out_valid), 128'd0);
      check("ar_count0", 128'(bus.count), 128'd0);
      check("ar_data0", bus.out_data, 128'd0);
      #1;
      rst = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      stream(8'h00, 16, 1'b1, ok);
      check("ar_b2b_data", bus.out_data, 128'h000102030405060708090A0B0C0D0E0F);
      check("ar_b2b_we", 128'(bus.we), 128'd1);

      // Word ordering on the 24-bit instance
      bus24.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus24.in_valid = 1'b1;
         bus24.in_data  = 8'(8'h11 * (i + 1));
         tick();
      end
      bus24.in_valid = 1'b0;
`ifdef WORD_PACKER_LSB_FIRST_EN
      exp24 = 24'h332211;
`else
      exp24 = 24'h112233;
`endif
      check("n24_order", 128'(bus24.out_data), 128'(exp24));
      check("n24_we", 128'(bus24.we), 128'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/word_packer.md
# word_packer

Upstream load stage for the SIMD AES datapath's `register` blocks. It accepts a stream of narrow words (bytes by default) over a valid/ready handshake and packs them into one N-bit block (128-bit AES state or key). It presents the packed block on `out_data`, held until consumed, and pulses `we` so the block can drive a downstream register's `en`/`D` directly. Assembly of the next block overlaps with the holding of the current one.

## Interface
- `N`, 128: output block width in bits. `N % W == 0` is required.
- `W`, 8: input word width in bits.
- `K` (derived), N/W: words per block. `K >= 2` is required.
- `CW` (derived), `$clog2(K)`: width of `count`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous discard of the partially assembled block.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: packer can take a word this cycle.
- `in_data`  in  W: input word.
- `out_valid`  out  1: `out_data` holds a complete block.
- `out_ready`  in  1: consumer takes the block this cycle.
- `out_data`  out  N: packed block, registered.
- `we`  out  1: one-cycle pulse when a new block is loaded into `out_data`.
- `count`  out  CW: number of words of the next block already assembled.

## Operation
- Internal state:
  - assembly buffer `asm` (N bits, internal only)
  - word counter `count`, range 0..K-1
  - output register `out_data` with flag `out_valid`
- Accept: a word is accepted when `in_valid && in_ready` at a rising edge.
- Word placement (default order): word i of the block (i = 0 first) lands in bits `[N-1-i*W -: W]`. The first word is therefore the MSBs, the AES byte-0 convention.
- Words 0..K-2: written into `asm`, then `count` increments.
- Word K-1 (completion):
  - `out_data <= {asm with word K-1 inserted}`
  - `out_valid <= 1`, `we <= 1` for exactly one cycle
  - `count <= 0`
- `in_ready = !clear && !(count == K-1 && out_valid && !out_ready)`. Only the completing word stalls, and only while the previous block is still unconsumed. Words 0..K-2 are never stalled.
- Drain: `out_valid && out_ready` with no completion in the same cycle sets `out_valid <= 0`. `out_data` keeps its value.
- Simultaneous drain and completion: `out_valid` stays 1, `out_data` takes the new block, and `we` pulses.
- `clear`:
  - `count <= 0`; `asm` contents become don't-care.
  - Beats `in_valid` in that cycle (`in_ready` = 0, so no word is accepted).
  - `out_valid`/`out_data` are unaffected; a held block can still drain in the same cycle.
- `we` is high only in the cycle after a completion. It is never asserted by a drain or a `clear`.

## Timing
- Reset (`rst` = 0, asynchronous, immediate):
  - `out_valid` = 0, `we` = 0, `count` = 0, `out_data` = 0, `asm` = 0
  - `in_ready` = 1 once `clear` is low
- Reset mid-block discards both the partial block and any held block. The first word accepted after release is word 0.
- Latency: `out_valid`/`we` rise on the same edge that accepts word K-1, so they are visible in the following cycle.
- Throughput: one word per cycle sustained with `out_ready` = 1. A K-word block completes every K cycles and there are no bubbles at block boundaries.
- Backpressure: with `out_ready` = 0, at most 2K-1 words are absorbed (one held block plus K-1 assembled words) before `in_ready` drops.
- `count` wraps K-1 -> 0 only on completion or `clear`.

## Configuration
- `WORD_PACKER_LSB_FIRST_EN` undefined: word i lands in bits `[N-1-i*W -: W]` (MSB-first, default).
- `WORD_PACKER_LSB_FIRST_EN` defined: word i lands in bits `[i*W +: W]` (LSB-first).
- Handshake, counter and timing are identical in both builds.

## Test plan
All scenarios use N=128, W=8 unless stated otherwise.
- Reset: hold `rst` = 0 over 3 edges with random inputs -> `out_valid` = 0, `we` = 0, `count` = 0, `out_data` = 0, `in_ready` = 1.
- Back-to-back block: bytes 8'h00..8'h0F on consecutive cycles, `out_ready` = 1 -> `out_data` = 128'h000102030405060708090A0B0C0D0E0F one cycle after the 16th accept. `we` is high exactly 1 cycle and `count` returns to 0.
- Backpressure handoff:
  - Send block A (16'h11 bytes), hold `out_ready` = 0, then send 16 bytes 8'h22 -> 15 are accepted, then `in_ready` = 0 with `count` = 15.
  - Raise `out_ready` -> in that cycle the 16th byte is accepted and A drains. Next cycle `out_data` = {16{8'h22}}, `out_valid` = 1, `we` = 1.
- Clear: accept 5 bytes, assert `clear` for 1 cycle with `in_valid` = 1 -> no accept, `count` = 0. The next 16 bytes 8'hA0..8'hAF form a clean block 128'hA0A1...AF.
- Async reset mid-block: `rst` low while `count` = 7 and `out_valid` = 1 -> outputs zero immediately, without a clock edge. After release, bytes 00..0F produce the same result as the back-to-back scenario.
- `WORD_PACKER_LSB_FIRST_EN` build, N=24, W=8: bytes 8'h11, 8'h22, 8'h33 -> `out_data` = 24'h332211. The default build gives 24'h112233.
